// File: rtl/mem_pkg.sv
// Shared definitions for the RV32I memory-access stage: write-back source
// encodings, load/store funct3 codes, access-size codes and FSM states.
package mem_pkg;

    // Write-back source select carried by WriteSrc
    typedef enum logic [1:0] {
        WS_ALU = 2'b00,
        WS_MEM = 2'b01,
        WS_PC4 = 2'b10,
        WS_IMM = 2'b11
    } write_src_e;

    // Load/store funct3 codes (stores use only the low two bits)
    typedef enum logic [2:0] {
        F3_B  = 3'b000,
        F3_H  = 3'b001,
        F3_W  = 3'b010,
        F3_BU = 3'b100,
        F3_HU = 3'b101
    } funct3_e;

    // Access size taken from funct3[1:0]; anything else is a word
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    // Memory handshake FSM states
    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage (master) and
// the data memory (slave).
interface mem_stage_if #(
    parameter int ADDR_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wdata;
    logic              ack;
    logic [31:0]       rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output ack, rdata
    );
endinterface

// File: rtl/load_align.sv
// Extracts the addressed byte/halfword from a read word and sign- or
// zero-extends it according to the load funct3. Unknown codes load a word.
module load_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the byte and halfword lanes selected by the low address bits
    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addr[1] ? i_rdata[31:16] : i_rdata[15:0];
    end

    // Extend the selected lane to 32 bits
    always_comb begin
        o_data = i_rdata;
        case (i_funct3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: drives the variable-latency data-memory bus,
// steers store lanes, aligns loads, resolves redirects, holds the MEM/WB
// register and stalls upstream while an access is outstanding.
// Optional build macro: MEM_MISALIGN_CHECK_EN adds misaligned-access
// suppression and the sticky misalign_o output.
module mem_stage
    import mem_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        RegWrite_i,
    input  logic        Branch_i,
    input  logic        Jump_i,
    input  logic        Ret_i,
    input  logic        MemWrite_i,
    input  logic        EQ_i,
    input  logic [1:0]  WriteSrc_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] regOp2_i,
    input  logic [31:0] pcPlus4_i,
    input  logic [31:0] pcPlusImm_i,
    input  logic [31:0] ImmOp_i,
    input  logic [4:0]  rd_i,
    mem_stage_if.master dmem,
    output logic        stall_o,
    output logic        PCsrc_o,
    output logic [31:0] PCtarget_o,
    output logic [31:0] ALUResultM_o,
    output logic        RegWrite_o,
    output logic [1:0]  WriteSrc_o,
    output logic [31:0] ALUout_o,
    output logic [31:0] ReadData_o,
    output logic [31:0] pcPlus4_o,
    output logic [31:0] ImmOp_o,
    output logic [4:0]  rd_o,
`ifdef MEM_MISALIGN_CHECK_EN
    output logic        misalign_o,
`endif
    output logic        err_o
);

    localparam int              CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] C_MAX = CNT_W'(MAX_WAIT);

    mem_state_e       r_state;
    mem_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err;

    logic             w_is_load;
    logic             w_access_req;
    logic             w_misalign;
    logic             w_access;
    logic [1:0]       w_size;
    logic             w_req;
    logic             w_stall;
    logic             w_timeout;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_load_data;

    logic             r_regwrite;
    logic [1:0]       r_writesrc;
    logic [31:0]      r_aluout;
    logic [31:0]      r_readdata;
    logic [31:0]      r_pcplus4;
    logic [31:0]      r_immop;
    logic [4:0]       r_rd;

    assign w_is_load    = (WriteSrc_i == WS_MEM);
    assign w_access_req = MemWrite_i | w_is_load;
    assign w_size       = funct3_i[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
    logic r_misalign;

    assign w_misalign = w_access_req &
                        (((w_size == SZ_HALF) & ALUout_i[0]) |
                         (w_size[1] & (ALUout_i[1:0] != 2'b00)));

    // Sticky record of any suppressed misaligned access
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_misalign <= 1'b0;
        else         r_misalign <= r_misalign | w_misalign;
    end

    assign misalign_o = r_misalign;
`else
    // Low address bits beyond lane selection are ignored
    assign w_misalign = 1'b0;
`endif

    assign w_access = w_access_req & ~w_misalign;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= MEM_IDLE;
        else         r_state <= w_state_nxt;
    end

    // Next state, request, stall and timeout decode
    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_stall     = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            MEM_IDLE: begin
                w_req = w_access;
                if (w_access && !dmem.ack) begin
                    w_stall     = 1'b1;
                    w_state_nxt = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                w_req = 1'b1;
                if (dmem.ack) begin
                    w_state_nxt = MEM_IDLE;
                end else if (r_cnt == C_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = MEM_IDLE;
                end else begin
                    w_stall = 1'b1;
                end
            end
            default: w_state_nxt = MEM_IDLE;
        endcase
    end

    // Wait counter: held at zero in IDLE, counts unacknowledged WAIT cycles
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                        r_cnt <= '0;
        else if (r_state == MEM_IDLE)       r_cnt <= '0;
        else if (!dmem.ack && r_cnt != C_MAX) r_cnt <= r_cnt + 1'b1;
    end

    // Sticky timeout flag, cleared only by reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_err <= 1'b0;
        else         r_err <= r_err | w_timeout;
    end

    // Store byte-lane enables and lane-replicated write data
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = regOp2_i;
        case (w_size)
            SZ_BYTE: begin
                w_be    = 4'b0001 << ALUout_i[1:0];
                w_wdata = {4{regOp2_i[7:0]}};
            end
            SZ_HALF: begin
                w_be    = ALUout_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{regOp2_i[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = regOp2_i;
            end
        endcase
    end

    load_align u_load_align (
        .i_addr   (ALUout_i[1:0]),
        .i_funct3 (funct3_i),
        .i_rdata  (dmem.rdata),
        .o_data   (w_load_data)
    );

    // MEM/WB register: loads a bubble while stalled, zero read data unless acked
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_regwrite <= 1'b0;
            r_writesrc <= 2'b00;
            r_aluout   <= '0;
            r_readdata <= '0;
            r_pcplus4  <= '0;
            r_immop    <= '0;
            r_rd       <= '0;
        end else begin
            r_regwrite <= RegWrite_i & ~w_stall;
            r_rd       <= w_stall ? 5'd0 : rd_i;
            r_writesrc <= WriteSrc_i;
            r_aluout   <= ALUout_i;
            r_pcplus4  <= pcPlus4_i;
            r_immop    <= ImmOp_i;
            r_readdata <= (w_req & dmem.ack) ? w_load_data : 32'd0;
        end
    end

    // Outputs; reset forces the request, stall and redirect low immediately
    assign dmem.req     = rst_ni & w_req;
    assign dmem.we      = rst_ni & w_req & MemWrite_i;
    assign dmem.addr    = {ALUout_i[ADDR_W-1:2], 2'b00};
    assign dmem.be      = w_be;
    assign dmem.wdata   = w_wdata;
    assign stall_o      = rst_ni & w_stall;
    assign PCsrc_o      = rst_ni & ((Branch_i & EQ_i) | Jump_i | Ret_i);
    assign PCtarget_o   = Ret_i ? {ALUout_i[31:1], 1'b0} : pcPlusImm_i;
    assign ALUResultM_o = ALUout_i;
    assign err_o        = r_err;

    assign RegWrite_o = r_regwrite;
    assign WriteSrc_o = r_writesrc;
    assign ALUout_o   = r_aluout;
    assign ReadData_o = r_readdata;
    assign pcPlus4_o  = r_pcplus4;
    assign ImmOp_o    = r_immop;
    assign rd_o       = r_rd;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: randomized loads, stores and redirects
// compared against an arithmetic reference model.
module tb_mem_stage;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        RegWrite_i, Branch_i, Jump_i, Ret_i, MemWrite_i, EQ_i;
    logic [1:0]  WriteSrc_i;
    logic [2:0]  funct3_i;
    logic [31:0] ALUout_i, regOp2_i, pcPlus4_i, pcPlusImm_i, ImmOp_i;
    logic [4:0]  rd_i;
    logic        stall_o, PCsrc_o, RegWrite_o, err_o;
    logic [31:0] PCtarget_o, ALUResultM_o, ALUout_o, ReadData_o, pcPlus4_o, ImmOp_o;
    logic [1:0]  WriteSrc_o;
    logic [4:0]  rd_o;
`ifdef MEM_MISALIGN_CHECK_EN
    logic        misalign_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_if #(.ADDR_W(32)) dmem_bus ();

    mem_stage #(.ADDR_W(32), .MAX_WAIT(MAX_WAIT)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .RegWrite_i(RegWrite_i), .Branch_i(Branch_i), .Jump_i(Jump_i), .Ret_i(Ret_i),
        .MemWrite_i(MemWrite_i), .EQ_i(EQ_i), .WriteSrc_i(WriteSrc_i), .funct3_i(funct3_i),
        .ALUout_i(ALUout_i), .regOp2_i(regOp2_i), .pcPlus4_i(pcPlus4_i),
        .pcPlusImm_i(pcPlusImm_i), .ImmOp_i(ImmOp_i), .rd_i(rd_i),
        .dmem(dmem_bus),
        .stall_o(stall_o), .PCsrc_o(PCsrc_o), .PCtarget_o(PCtarget_o),
        .ALUResultM_o(ALUResultM_o), .RegWrite_o(RegWrite_o), .WriteSrc_o(WriteSrc_o),
        .ALUout_o(ALUout_o), .ReadData_o(ReadData_o), .pcPlus4_o(pcPlus4_o),
        .ImmOp_o(ImmOp_o), .rd_o(rd_o),
`ifdef MEM_MISALIGN_CHECK_EN
        .misalign_o(misalign_o),
`endif
        .err_o(err_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_load(logic [31:0] addr, logic [2:0] f3, logic [31:0] word);
        logic [31:0] v;
        int          boff;
        int          hoff;
        boff = 8 * int'(addr[1:0]);
        hoff = addr[1] ? 16 : 0;
        case (f3)
            3'b000: begin v = (word >> boff) & 32'hFF;   if (v >= 32'h80)   v = v - 32'h100;   end
            3'b001: begin v = (word >> hoff) & 32'hFFFF; if (v >= 32'h8000) v = v - 32'h10000; end
            3'b100: v = (word >> boff) & 32'hFF;
            3'b101: v = (word >> hoff) & 32'hFFFF;
            default: v = word;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] ref_be(logic [31:0] addr, logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 4'(1 << addr[1:0]);
        if (f3[1:0] == 2'b01) return 4'(3 << (addr[1] ? 2 : 0));
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(logic [31:0] d, logic [2:0] f3);
        if (f3[1:0] == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (f3[1:0] == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    // Random address naturally aligned for the access size
    function automatic logic [31:0] rand_addr(logic [2:0] f3);
        logic [31:0] a;
        a = $urandom;
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        else if (f3[1]) a[1:0] = 2'b00;
        return a;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic clear_inputs();
        RegWrite_i = 0; Branch_i = 0; Jump_i = 0; Ret_i = 0; MemWrite_i = 0; EQ_i = 0;
        WriteSrc_i = 2'b00; funct3_i = 3'b000; ALUout_i = 0; regOp2_i = 0;
        pcPlus4_i = 0; pcPlusImm_i = 0; ImmOp_i = 0; rd_i = 0;
        dmem_bus.ack = 0; dmem_bus.rdata = 0;
    endtask

    // Present one load/store, ack after wait_n cycles, and record what was seen
    task automatic run_access(
        input  logic        is_store, input logic [2:0] f3, input logic [31:0] addr,
        input  logic [31:0] sdata, input logic [31:0] rword, input int wait_n, input logic [4:0] rd,
        output int stall_n, output int bubble_bad, output int req_low, output int hold_bad,
        output logic [3:0] be_v, output logic [31:0] wd_v, output logic we_v, output logic [31:0] addr_v,
        output logic [31:0] rdata_v, output logic regw_v, output logic [4:0] rd_v);
        stall_n = 0; bubble_bad = 0; req_low = 0; hold_bad = 0;
        be_v = 0; wd_v = 0; we_v = 0; addr_v = 0;
        @(negedge clk);
        MemWrite_i = is_store; WriteSrc_i = is_store ? 2'b00 : 2'b01; RegWrite_i = ~is_store;
        funct3_i = f3; ALUout_i = addr; regOp2_i = sdata; rd_i = rd;
        pcPlus4_i = $urandom; pcPlusImm_i = $urandom; ImmOp_i = $urandom;
        dmem_bus.rdata = rword;
        for (int c = 0; c <= wait_n; c++) begin
            if (c > 0) @(negedge clk);
            dmem_bus.ack = (c == wait_n);
            #1;
            if (stall_o) stall_n++;
            if (!dmem_bus.req) req_low++;
            if (c == 0) begin
                be_v = dmem_bus.be; wd_v = dmem_bus.wdata; we_v = dmem_bus.we; addr_v = dmem_bus.addr;
            end else if (dmem_bus.be !== be_v || dmem_bus.wdata !== wd_v ||
                         dmem_bus.we !== we_v || dmem_bus.addr !== addr_v) begin
                hold_bad++;
            end
            @(posedge clk); #1;
            if (c < wait_n && (RegWrite_o !== 1'b0 || rd_o !== 5'd0)) bubble_bad++;
        end
        rdata_v = ReadData_o; regw_v = RegWrite_o; rd_v = rd_o;
        @(negedge clk);
        clear_inputs();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_ni = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (RegWrite_o !== 1'b0 || rd_o !== 5'd0 || ReadData_o !== 32'd0 || ALUout_o !== 32'd0) begin
            failures++; $display("FAIL reset_memwb got regw=%b rd=%0d rdata=%h alu=%h required all 0", RegWrite_o, rd_o, ReadData_o, ALUout_o); end
        checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", err_o); end
        WriteSrc_i = 2'b01; RegWrite_i = 1; ALUout_i = 32'h100;
        #1;
        checks++; if (dmem_bus.req !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL reset_req_stall got req=%b stall=%b required 0 0", dmem_bus.req, stall_o); end
        clear_inputs();
        @(negedge clk);
        rst_ni = 1;
    endtask

    task automatic test_load_zero_wait();
        int s, b, rl, h; logic [3:0] be; logic [31:0] wd, ad, rdv; logic we, rw; logic [4:0] rdo;
        run_access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEAD_BEEF, 0, 5'd7, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (s !== 0) begin failures++; $display("FAIL lw0_stall got=%0d required=0", s); end
        checks++; if (rl !== 0 || ad !== 32'h100) begin failures++; $display("FAIL lw0_req got reqlow=%0d addr=%h required 0 100", rl, ad); end
        checks++; if (rdv !== 32'hDEAD_BEEF || rw !== 1'b1 || rdo !== 5'd7) begin
            failures++; $display("FAIL lw0_wb got data=%h regw=%b rd=%0d required deadbeef 1 7", rdv, rw, rdo); end
    endtask

    task automatic test_load_wait();
        int s, b, rl, h; logic [3:0] be; logic [31:0] wd, ad, rdv, a, w, exp; logic we, rw; logic [4:0] rdo; logic [2:0] f3; int wn;
        run_access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF_FFFF, 3, 5'd9, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (s !== 3) begin failures++; $display("FAIL lb_stall_cycles got=%0d required=3", s); end
        checks++; if (b !== 0) begin failures++; $display("FAIL lb_bubbles got bad=%0d required=0", b); end
        checks++; if (rdv !== 32'hFFFF_FF80 || rw !== 1'b1 || rdo !== 5'd9) begin
            failures++; $display("FAIL lb_data got=%h regw=%b rd=%0d required ffffff80 1 9", rdv, rw, rdo); end
        run_access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF_FFFF, 3, 5'd9, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (rdv !== 32'h0000_0080) begin failures++; $display("FAIL lbu_data got=%h required=00000080", rdv); end
        for (int i = 0; i < 14; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a = rand_addr(f3); w = $urandom; wn = $urandom_range(0, 4);
            exp = ref_load(a, f3, w);
            run_access(1'b0, f3, a, 32'd0, w, wn, 5'(i + 1), s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
            checks++; if (rdv !== exp || s !== wn || b !== 0 || h !== 0 || rl !== 0) begin
                failures++; $display("FAIL rand_load f3=%0d addr=%h got data=%h stall=%0d bub=%0d hold=%0d required data=%h stall=%0d",
                                     f3, a, rdv, s, b, h, exp, wn); end
        end
    endtask

    task automatic test_store();
        int s, b, rl, h; logic [3:0] be; logic [31:0] wd, ad, rdv, a, d; logic we, rw; logic [4:0] rdo; logic [2:0] f3; int wn;
        run_access(1'b1, 3'b001, 32'h202, 32'h0000_1234, 32'd0, 0, 5'd0, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (be !== 4'b1100 || wd !== 32'h1234_1234 || we !== 1'b1 || ad !== 32'h200) begin
            failures++; $display("FAIL sh_lanes got be=%b wdata=%h we=%b addr=%h required 1100 12341234 1 200", be, wd, we, ad); end
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 2));
            a = rand_addr(f3); d = $urandom; wn = $urandom_range(0, 3);
            run_access(1'b1, f3, a, d, 32'd0, wn, 5'd0, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
            checks++; if (be !== ref_be(a, f3) || wd !== ref_wdata(d, f3) || we !== 1'b1 ||
                          ad !== (a & 32'hFFFF_FFFC) || s !== wn || h !== 0 || rw !== 1'b0) begin
                failures++; $display("FAIL rand_store f3=%0d addr=%h got be=%b wd=%h we=%b stall=%0d hold=%0d regw=%b required be=%b wd=%h stall=%0d",
                                     f3, a, be, wd, we, s, h, rw, ref_be(a, f3), ref_wdata(d, f3), wn); end
        end
    endtask

    task automatic test_redirect();
        logic exp_src; logic [31:0] exp_tgt;
        @(negedge clk);
        Branch_i = 1; EQ_i = 1; pcPlusImm_i = 32'h40; #1;
        checks++; if (PCsrc_o !== 1'b1 || PCtarget_o !== 32'h40) begin
            failures++; $display("FAIL branch_taken got src=%b tgt=%h required 1 40", PCsrc_o, PCtarget_o); end
        clear_inputs(); Ret_i = 1; ALUout_i = 32'h85; pcPlusImm_i = 32'h40; #1;
        checks++; if (PCsrc_o !== 1'b1 || PCtarget_o !== 32'h84) begin
            failures++; $display("FAIL ret_target got src=%b tgt=%h required 1 84", PCsrc_o, PCtarget_o); end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            Branch_i = 1'($urandom); EQ_i = 1'($urandom); Jump_i = 1'($urandom_range(0, 3) == 0);
            Ret_i = 1'($urandom_range(0, 3) == 0); ALUout_i = $urandom; pcPlusImm_i = $urandom;
            WriteSrc_i = 2'b00; MemWrite_i = 0;
            exp_src = (Branch_i && EQ_i) || Jump_i || Ret_i;
            exp_tgt = Ret_i ? (ALUout_i & 32'hFFFF_FFFE) : pcPlusImm_i;
            #1;
            checks++; if (PCsrc_o !== exp_src || PCtarget_o !== exp_tgt || ALUResultM_o !== ALUout_i || stall_o !== 1'b0) begin
                failures++; $display("FAIL rand_redirect got src=%b tgt=%h fwd=%h stall=%b required src=%b tgt=%h fwd=%h",
                                     PCsrc_o, PCtarget_o, ALUResultM_o, stall_o, exp_src, exp_tgt, ALUout_i); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_back_to_back();
        logic e_rw, is_ld; logic [1:0] e_ws; logic [31:0] e_alu, e_pc4, e_imm, e_rdata; logic [4:0] e_rd; logic [2:0] f3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            is_ld = 1'($urandom);
            if (is_ld) begin
                f3 = 3'($urandom_range(0, 7)); WriteSrc_i = 2'b01; funct3_i = f3;
                ALUout_i = rand_addr(f3); dmem_bus.ack = 1; dmem_bus.rdata = $urandom;
            end else begin
                WriteSrc_i = ($urandom_range(0, 2) == 0) ? 2'b00 : (($urandom_range(0, 1) == 0) ? 2'b10 : 2'b11);
                funct3_i = 3'($urandom); ALUout_i = $urandom; dmem_bus.ack = 0; dmem_bus.rdata = $urandom;
            end
            RegWrite_i = 1'($urandom); rd_i = 5'($urandom); pcPlus4_i = $urandom; ImmOp_i = $urandom;
            e_rw = RegWrite_i; e_ws = WriteSrc_i; e_alu = ALUout_i; e_pc4 = pcPlus4_i; e_imm = ImmOp_i; e_rd = rd_i;
            e_rdata = ref_load(ALUout_i, funct3_i, dmem_bus.rdata);
            #1;
            checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL b2b_stall got=%b required=0", stall_o); end
            @(posedge clk); #1;
            checks++; if (RegWrite_o !== e_rw || WriteSrc_o !== e_ws || ALUout_o !== e_alu || pcPlus4_o !== e_pc4 ||
                          ImmOp_o !== e_imm || rd_o !== e_rd || (is_ld && ReadData_o !== e_rdata)) begin
                failures++; $display("FAIL b2b_memwb got rw=%b ws=%b alu=%h pc4=%h imm=%h rd=%0d data=%h required rw=%b ws=%b alu=%h pc4=%h imm=%h rd=%0d data=%h",
                                     RegWrite_o, WriteSrc_o, ALUout_o, pcPlus4_o, ImmOp_o, rd_o, ReadData_o,
                                     e_rw, e_ws, e_alu, e_pc4, e_imm, e_rd, e_rdata); end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_timeout();
        int s, b, rl, h, stall_n; logic [3:0] be; logic [31:0] wd, ad, rdv; logic we, rw; logic [4:0] rdo; logic done;
        stall_n = 0; done = 0;
        @(negedge clk);
        WriteSrc_i = 2'b01; RegWrite_i = 1; funct3_i = 3'b010; ALUout_i = 32'h300; rd_i = 5'd3;
        dmem_bus.ack = 0; dmem_bus.rdata = 32'hCAFE_F00D;
        for (int c = 0; c < MAX_WAIT + 8; c++) begin
            #1;
            if (!stall_o) begin done = 1; break; end
            stall_n++;
            @(negedge clk);
        end
        checks++; if (!done || stall_n !== MAX_WAIT + 1) begin
            failures++; $display("FAIL timeout_stall got done=%b cycles=%0d required 1 %0d", done, stall_n, MAX_WAIT + 1); end
        @(posedge clk); #1;
        checks++; if (err_o !== 1'b1 || ReadData_o !== 32'd0 || RegWrite_o !== 1'b1) begin
            failures++; $display("FAIL timeout_wb got err=%b data=%h regw=%b required 1 0 1", err_o, ReadData_o, RegWrite_o); end
        @(negedge clk);
        clear_inputs();
        run_access(1'b0, 3'b010, 32'h400, 32'd0, 32'h1111_2222, 1, 5'd4, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (err_o !== 1'b1 || rdv !== 32'h1111_2222) begin
            failures++; $display("FAIL timeout_sticky got err=%b data=%h required 1 11112222", err_o, rdv); end
    endtask

    task automatic test_reset_mid_wait();
        int s, b, rl, h; logic [3:0] be; logic [31:0] wd, ad, rdv; logic we, rw; logic [4:0] rdo;
        @(negedge clk);
        WriteSrc_i = 2'b01; RegWrite_i = 1; funct3_i = 3'b010; ALUout_i = 32'h500; rd_i = 5'd5; dmem_bus.ack = 0;
        repeat (3) @(negedge clk);
        #2;
        rst_ni = 0;
        #1;
        checks++; if (dmem_bus.req !== 1'b0 || stall_o !== 1'b0 || err_o !== 1'b0 || RegWrite_o !== 1'b0 ||
                      rd_o !== 5'd0 || ALUout_o !== 32'd0 || pcPlus4_o !== 32'd0) begin
            failures++; $display("FAIL rst_mid_wait got req=%b stall=%b err=%b regw=%b rd=%0d alu=%h required all 0",
                                 dmem_bus.req, stall_o, err_o, RegWrite_o, rd_o, ALUout_o); end
        @(negedge clk);
        clear_inputs();
        rst_ni = 1;
        run_access(1'b0, 3'b101, 32'h602, 32'd0, 32'hABCD_1234, 1, 5'd6, s, b, rl, h, be, wd, we, ad, rdv, rw, rdo);
        checks++; if (rdv !== 32'h0000_ABCD || rw !== 1'b1 || s !== 1 || err_o !== 1'b0) begin
            failures++; $display("FAIL rst_recover got data=%h regw=%b stall=%0d err=%b required 0000abcd 1 1 0", rdv, rw, s, err_o); end
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_load_wait();
        test_store();
        test_redirect();
        test_back_to_back();
        test_timeout();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
